// File: rtl/sram_read_checker_pkg.sv
// Shared types and defaults for the SRAM read checker.
// SRAM_CHK_STOP_ON_ERR_EN adds the FAIL state (halt on first mismatch).
package sram_read_checker_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int PAT_W_DEF  = 6;
  localparam int ERR_W      = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SAMPLE,
    ST_CMP,
    ST_DONE
`ifdef SRAM_CHK_STOP_ON_ERR_EN
    , ST_FAIL
`endif
  } state_t;

endpackage

// File: rtl/sram_read_checker_err_log.sv
// Saturating mismatch counter plus first-failure capture (address, read data, expected).
module sram_chk_err_log
  import sram_read_checker_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              mismatch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp
);

  localparam logic [ERR_W-1:0] ERR_ONE = 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      err_count <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else if (mismatch) begin
      err_count <= sat_inc(err_count);
      // Only the first mismatch since start is recorded.
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr;
        fail_data <= rd_data;
        fail_exp  <= exp_data;
      end
    end
  end

endmodule

// File: rtl/sram_read_checker.sv
// Sweeps SRAM 0..LAST_ADDR with async read cycles and compares against the pattern ROM.
// Optional macro SRAM_CHK_STOP_ON_ERR_EN: stop in FAIL on the first mismatch.
module sram_read_checker
  import sram_read_checker_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          PAT_W     = PAT_W_DEF,
  parameter int          READ_WAIT = 2,
  parameter int unsigned LAST_ADDR = 2**18-1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              go,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              oe_n,
  output logic              we_n,
  input  logic [DATA_W-1:0] sram_din,
  output logic [PAT_W-1:0]  pattern,
  input  logic [DATA_W-1:0] expected,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp
);

  localparam logic [ADDR_W-1:0] LAST      = LAST_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [3:0]        WAIT_INIT = 4'(READ_WAIT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_go_q;
  logic [3:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_rd_q;
  logic              w_parked;
  logic              w_start;
  logic              w_mismatch;

  always_comb begin
    w_parked = (r_state == ST_IDLE) || (r_state == ST_DONE);
`ifdef SRAM_CHK_STOP_ON_ERR_EN
    w_parked = w_parked || (r_state == ST_FAIL);
`endif
  end

  assign w_start    = go & ~r_go_q & w_parked;
  assign w_mismatch = (r_state == ST_CMP) && (r_rd_q != expected);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_go_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_go_q  <= go;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ADDR:   w_state_nxt = ST_WAIT;
      ST_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = ST_CMP;
      ST_CMP: begin
        if (sram_addr == LAST) w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_ADDR;
`ifdef SRAM_CHK_STOP_ON_ERR_EN
        if (w_mismatch) w_state_nxt = ST_FAIL;
`endif
      end
      default:   if (w_start) w_state_nxt = ST_ADDR;
    endcase
  end

  always_comb begin
    oe_n = ~((r_state == ST_ADDR) || (r_state == ST_WAIT) || (r_state == ST_SAMPLE));
    we_n = 1'b1;
    busy = ~w_parked;
    done = (r_state == ST_DONE);
`ifdef SRAM_CHK_STOP_ON_ERR_EN
    done = done || (r_state == ST_FAIL);
`endif
    pass = (r_state == ST_DONE) && !fail;
  end

  // Address, pattern and wait counter; the address only advances on CMP->ADDR, so it never wraps.
  always_ff @(posedge clk) begin
    if (clr) begin
      sram_addr  <= '0;
      pattern    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_start)
        sram_addr <= '0;
      else if (r_state == ST_CMP && w_state_nxt == ST_ADDR)
        sram_addr <= sram_addr + ADDR_ONE;
      if (r_state == ST_ADDR) begin
        pattern    <= sram_addr[PAT_W-1:0];
        r_wait_cnt <= WAIT_INIT;
      end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_SAMPLE) r_rd_q <= sram_din;
  end

  sram_chk_err_log #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_err_log (
    .clk       (clk),
    .clr       (clr),
    .clear     (w_start),
    .mismatch  (w_mismatch),
    .addr      (sram_addr),
    .rd_data   (r_rd_q),
    .exp_data  (expected),
    .err_count (err_count),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_exp  (fail_exp)
  );

endmodule

// File: tb/tb_sram_read_checker.sv
// Directed bench for sram_read_checker with a behavioural SRAM/ROM model (LAST_ADDR=15).
module tb_sram_read_checker;
  import sram_read_checker_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int PW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr, go;
  logic [AW-1:0] sram_addr;
  logic          oe_n, we_n;
  logic [DW-1:0] sram_din;
  logic [PW-1:0] pattern;
  logic [DW-1:0] expected;
  logic          busy, done, pass, fail;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data, fail_exp;
  logic [15:0]   mask;

  logic          s_clear, s_mis, s_fail;
  logic [AW-1:0] s_addr, s_faddr;
  logic [DW-1:0] s_fdata, s_fexp;
  logic [15:0]   s_cnt;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] rom(input logic [5:0] a);
    return {a, ~a, a[3:0]} ^ 16'h3C5A;
  endfunction

  always @(posedge clk) expected <= rom(pattern);
  assign sram_din = oe_n ? 16'h0000 : (mask[sram_addr[3:0]] ? 16'hDEAD : rom(sram_addr[5:0]));

  sram_read_checker #(
    .ADDR_W(AW), .DATA_W(DW), .PAT_W(PW), .READ_WAIT(2), .LAST_ADDR(15)
  ) dut (
    .clk(clk), .clr(clr), .go(go), .sram_addr(sram_addr), .oe_n(oe_n), .we_n(we_n),
    .sram_din(sram_din), .pattern(pattern), .expected(expected), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp)
  );

  sram_chk_err_log #(.ADDR_W(AW), .DATA_W(DW)) u_log (
    .clk(clk), .clr(clr), .clear(s_clear), .mismatch(s_mis), .addr(s_addr),
    .rd_data(16'h1111), .exp_data(16'h2222), .err_count(s_cnt), .fail(s_fail),
    .fail_addr(s_faddr), .fail_data(s_fdata), .fail_exp(s_fexp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a sweep and counts busy / oe_n-low / oe_n-run / we_n-low cycles until done.
  task automatic run_sweep(input bit hold, output int busy_c, output int oe_c,
                           output int runs, output int we_c);
    logic prev_oe;
    busy_c = 0; oe_c = 0; runs = 0; we_c = 0; prev_oe = 1'b1;
    @(negedge clk) go = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!hold) go = 1'b0;
      if (busy) busy_c++;
      if (!oe_n) oe_c++;
      if (!oe_n && prev_oe) runs++;
      if (!we_n) we_c++;
      prev_oe = oe_n;
      if (done) break;
    end
  endtask

  typedef struct {
    logic [15:0] mask;
    int          n_err;
    int          first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bc, oc, rc, wc, last, n_err, bcnt;

    vecs[0] = '{16'h0000, 0, -1};
    vecs[1] = '{16'h0080, 1, 7};
    vecs[2] = '{16'h1208, 3, 3};
    vecs[3] = '{16'h0000, 0, -1};
    vecs[4] = '{16'hFFFF, 16, 0};
    vecs[5] = '{16'h8000, 1, 15};
    vecs[6] = '{16'h8001, 2, 0};

    clr = 1'b1; go = 1'b0; mask = '0;
    s_clear = 1'b0; s_mis = 1'b0; s_addr = 18'h01234;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_pattern", 32'(pattern), 0);
    chk("rst_flags", {28'd0, busy, done, pass, fail}, 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_fail_regs", 32'(fail_addr) | 32'(fail_data) | 32'(fail_exp), 0);
    clr = 1'b0;

    for (int i = 0; i < 7; i++) begin
      mask = vecs[i].mask;
      run_sweep(1'b0, bc, oc, rc, wc);
`ifdef SRAM_CHK_STOP_ON_ERR_EN
      last  = (vecs[i].first < 0) ? 15 : vecs[i].first;
      n_err = (vecs[i].first < 0) ? 0 : 1;
`else
      last  = 15;
      n_err = vecs[i].n_err;
`endif
      chk($sformatf("v%0d_done", i), 32'(done), 1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'((last + 1) * 5));
      chk($sformatf("v%0d_oe_low", i), 32'(oc), 32'((last + 1) * 4));
      chk($sformatf("v%0d_oe_runs", i), 32'(rc), 32'(last + 1));
      chk($sformatf("v%0d_we_low", i), 32'(wc), 0);
      chk($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(last));
      chk($sformatf("v%0d_err", i), 32'(err_count), 32'(n_err));
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(n_err == 0));
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(n_err != 0));
      chk($sformatf("v%0d_fail_addr", i), 32'(fail_addr),
          (vecs[i].first < 0) ? 0 : 32'(vecs[i].first));
      chk($sformatf("v%0d_fail_data", i), 32'(fail_data),
          (vecs[i].first < 0) ? 0 : 32'h0000DEAD);
      chk($sformatf("v%0d_fail_exp", i), 32'(fail_exp),
          (vecs[i].first < 0) ? 0 : 32'(rom(6'(vecs[i].first))));
    end

    // clr during WAIT of address 5
`ifdef SRAM_CHK_STOP_ON_ERR_EN
    mask = 16'h0000;
`else
    mask = 16'h0004;
`endif
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (sram_addr == 18'd5 && !oe_n) break;
      @(negedge clk);
    end
    chk("clr_reach_addr5", 32'(sram_addr), 5);
`ifndef SRAM_CHK_STOP_ON_ERR_EN
    chk("clr_pre_err", 32'(err_count), 1);
`endif
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    chk("clr_oe_n", 32'(oe_n), 1);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_addr", 32'(sram_addr), 0);
    chk("clr_err", 32'(err_count), 0);
    mask = '0;
    run_sweep(1'b0, bc, oc, rc, wc);
    chk("post_clr_busy_cycles", 32'(bc), 80);
    chk("post_clr_pass", 32'(pass), 1);

    // go held high across the sweep and into DONE
    mask = 16'h0008;
    run_sweep(1'b1, bc, oc, rc, wc);
    chk("held_done", 32'(done), 1);
    chk("held_err", 32'(err_count), 1);
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("held_no_restart", 32'(bcnt), 0);
    chk("held_still_done", 32'(done), 1);
    mask = '0;
    @(negedge clk) go = 1'b0;
    run_sweep(1'b1, bc, oc, rc, wc);
    chk("rearm_busy_cycles", 32'(bc), 80);
    chk("rearm_err", 32'(err_count), 0);
    chk("rearm_fail", 32'(fail), 0);
    chk("rearm_fail_addr", 32'(fail_addr), 0);
    chk("rearm_pass", 32'(pass), 1);
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("rearm_no_second", 32'(bcnt), 0);

    // go edge coincident with clr
    @(negedge clk) go = 1'b0;
    @(negedge clk) begin go = 1'b1; clr = 1'b1; end
    @(negedge clk) begin go = 1'b0; clr = 1'b0; end
    chk("goclr_busy", 32'(busy), 0);
    chk("goclr_done", 32'(done), 0);
    @(negedge clk);
    chk("goclr_idle", 32'(busy), 0);

    // error counter saturation through the logging sub-module
    @(negedge clk) s_mis = 1'b1;
    @(negedge clk) s_addr = 18'h02222;
    repeat (65533) @(negedge clk);
    s_mis = 1'b0;
    chk("sat_before_max", 32'(s_cnt), 32'h0000FFFE);
    chk("sat_first_addr", 32'(s_faddr), 32'h00001234);
    s_mis = 1'b1;
    repeat (6) @(negedge clk);
    s_mis = 1'b0;
    chk("sat_hold_max", 32'(s_cnt), 32'h0000FFFF);
    @(negedge clk) s_clear = 1'b1;
    @(negedge clk) s_clear = 1'b0;
    chk("sat_clear", 32'(s_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
